// File: rtl/misc_pkg.sv
// Shared definitions for the Misc "branchy" datapath and its exhaustive-search solver.
package misc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    localparam int NA_DEF = 8;
    localparam int NB_DEF = 4;
    // Evaluation width; callers zero-extend their operands and keep the low bits of the result.
    localparam int MISC_W = 32;

    function automatic logic [MISC_W-1:0] misc_branchy(input logic [MISC_W-1:0] a,
                                                        input logic [MISC_W-1:0] bz);
        return (a > bz) ? (a + bz) : (a - bz);
    endfunction

endpackage

// File: rtl/misc_branchy_eval.sv
// Combinational check: does branchy(cand, bz), taken mod 2**NA, equal the target y?
module misc_branchy_eval
    import misc_pkg::*;
#(
    parameter int NA = NA_DEF
) (
    input  logic [NA-1:0] cand,
    input  logic [NA-1:0] bz,
    input  logic [NA-1:0] y,
    output logic          match
);

    localparam logic [MISC_W-1:0] MASK = (MISC_W'(1) << NA) - MISC_W'(1);

    logic [MISC_W-1:0] res;

    always_comb begin
        res   = misc_branchy(MISC_W'(cand), MISC_W'(bz));
        match = ((res ^ MISC_W'(y)) & MASK) == '0;
    end

endmodule

// File: rtl/misc_branchy_solver.sv
// Sequential inverse of the branchy datapath: scans every A for a given (Y, B) and
// reports the smallest match and the match count behind a valid/ready handshake.
module misc_branchy_solver
    import misc_pkg::*;
#(
    parameter int NA         = NA_DEF,
    parameter int NB         = NB_DEF,
    parameter int EARLY_EXIT = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [NA-1:0] Y,
    input  logic [NB-1:0] B,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic          FOUND,
    output logic [NA-1:0] A_OUT,
    output logic [NA:0]   NMATCH
);

    state_t        state, state_nx;
    logic [NA-1:0] y_q, y_nx;
    logic [NA-1:0] bz_q, bz_nx;
    logic [NA-1:0] cand, cand_nx;
    logic [NA-1:0] a_q, a_nx;
    logic          found_q, found_nx;
    logic [NA:0]   n_q, n_nx;
    logic          match;

    misc_branchy_eval #(.NA(NA)) u_eval (
        .cand  (cand),
        .bz    (bz_q),
        .y     (y_q),
        .match (match)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            y_q     <= '0;
            bz_q    <= '0;
            cand    <= '0;
            a_q     <= '0;
            found_q <= 1'b0;
            n_q     <= '0;
        end else begin
            state   <= state_nx;
            y_q     <= y_nx;
            bz_q    <= bz_nx;
            cand    <= cand_nx;
            a_q     <= a_nx;
            found_q <= found_nx;
            n_q     <= n_nx;
        end
    end

    always_comb begin
        state_nx = state;
        y_nx     = y_q;
        bz_nx    = bz_q;
        cand_nx  = cand;
        a_nx     = a_q;
        found_nx = found_q;
        n_nx     = n_q;
        unique case (state)
            IDLE: begin
                if (IN_VALID) begin
                    y_nx     = Y;
                    bz_nx    = {{(NA-NB){1'b0}}, B};
                    cand_nx  = '0;
                    a_nx     = '0;
                    found_nx = 1'b0;
                    n_nx     = '0;
                    state_nx = SEARCH;
                end
            end
            SEARCH: begin
                if (match) begin
                    n_nx = n_q + (NA+1)'(1);
                    if (!found_q) begin
                        a_nx     = cand;
                        found_nx = 1'b1;
                    end
                end
                // Terminal detect on all-ones so cand never wraps back to zero.
                if ((cand == '1) || ((EARLY_EXIT != 0) && match)) begin
                    state_nx = DONE;
                end else begin
                    cand_nx = cand + NA'(1);
                end
            end
            DONE: begin
                if (OUT_READY) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign FOUND     = found_q;
    assign A_OUT     = a_q;
    assign NMATCH    = n_q;

endmodule

// File: tb/tb_misc_branchy_solver.sv
// Directed and randomized checks of the solver (full-scan and early-exit builds)
// against a brute-force model of the branchy function.
module tb_misc_branchy_solver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_valid, in_ready, out_valid, out_ready, found;
    logic [7:0] y_in [2];
    logic [3:0] b_in [2];
    logic [7:0] a_out [2];
    logic [8:0] nmatch [2];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    misc_branchy_solver #(.NA(8), .NB(4), .EARLY_EXIT(0)) dut_full (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .Y(y_in[0]), .B(b_in[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
        .FOUND(found[0]), .A_OUT(a_out[0]), .NMATCH(nmatch[0])
    );

    misc_branchy_solver #(.NA(8), .NB(4), .EARLY_EXIT(1)) dut_early (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .Y(y_in[1]), .B(b_in[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
        .FOUND(found[1]), .A_OUT(a_out[1]), .NMATCH(nmatch[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Brute force over every A using the plain definition of the function.
    task automatic model(input int y, input int b, input bit early,
                         output int e_found, output int e_a, output int e_n, output int e_lat);
        e_found = 0; e_a = 0; e_n = 0; e_lat = 256;
        for (int a = 0; a < 256; a++) begin
            int f;
            f = (a > b) ? (a + b) % 256 : (a - b + 256) % 256;
            if (f == y) begin
                if (e_found == 0) begin
                    e_a = a;
                    if (early) e_lat = a + 1;
                end
                e_found = 1;
                e_n++;
            end
        end
        if (early && e_found == 1) e_n = 1;
    endtask

    // Issue one request on instance s and check latency and results.
    task automatic run_req(input int s, input int y, input int b, input string tag);
        int n, e_found, e_a, e_n, e_lat;
        model(y, b, (s == 1), e_found, e_a, e_n, e_lat);
        @(negedge clk);
        in_valid[s] = 1'b1;
        y_in[s]     = 8'(y);
        b_in[s]     = 4'(b);
        @(negedge clk);
        in_valid[s] = 1'b0;
        check({tag, "_busy"}, int'(in_ready[s]), 0);
        n = 0;
        while (!out_valid[s] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, e_lat);
        check({tag, "_found"}, int'(found[s]), e_found);
        check({tag, "_a_out"}, int'(a_out[s]), e_a);
        check({tag, "_nmatch"}, int'(nmatch[s]), e_n);
        out_ready[s] = 1'b1;
        @(negedge clk);
        out_ready[s] = 1'b0;
        check({tag, "_vld_drop"}, int'(out_valid[s]), 0);
        check({tag, "_ready_back"}, int'(in_ready[s]), 1);
    endtask

    initial begin
        int e_found, e_a, e_n, e_lat;
        int k;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        y_in[0] = '0; y_in[1] = '0;
        b_in[0] = '0; b_in[1] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst%0d_in_ready", s), int'(in_ready[s]), 1);
            check($sformatf("rst%0d_out_valid", s), int'(out_valid[s]), 0);
            check($sformatf("rst%0d_found", s), int'(found[s]), 0);
            check($sformatf("rst%0d_a_out", s), int'(a_out[s]), 0);
            check($sformatf("rst%0d_nmatch", s), int'(nmatch[s]), 0);
        end

        // Directed cases from the plan, full-scan build.
        run_req(0, 10, 3, "y10b3");
        check("y10b3_a7", int'(a_out[0]), 7);
        run_req(0, 255, 1, "y255b1");
        check("y255b1_n2", int'(nmatch[0]), 2);
        run_req(0, 2, 2, "y2b2");
        check("y2b2_none", int'(nmatch[0]), 0);
        run_req(0, 1, 15, "y1b15");
        check("y1b15_a242", int'(a_out[0]), 242);

        // Early-exit build.
        run_req(1, 255, 1, "early_y255b1");
        check("early_y255b1_a0", int'(a_out[1]), 0);
        run_req(1, 10, 3, "early_y10b3");
        run_req(1, 2, 2, "early_nomatch");

        // Randomized requests on both builds.
        for (int i = 0; i < 5; i++) begin
            run_req(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                    $sformatf("rnd_full%0d", i));
            run_req(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                    $sformatf("rnd_early%0d", i));
        end

        // Backpressure: results held in DONE, new request and input changes ignored.
        model(10, 3, 1'b0, e_found, e_a, e_n, e_lat);
        @(negedge clk);
        in_valid[0] = 1'b1; y_in[0] = 8'd10; b_in[0] = 4'd3;
        @(negedge clk);
        in_valid[0] = 1'b0;
        k = 0;
        while (!out_valid[0] && k < 400) begin @(negedge clk); k++; end
        check("bp_latency", k, 256);
        in_valid[0] = 1'b1; y_in[0] = 8'd0; b_in[0] = 4'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid[0]), 1);
            check("bp_in_ready", int'(in_ready[0]), 0);
            check("bp_a_out", int'(a_out[0]), e_a);
            check("bp_nmatch", int'(nmatch[0]), e_n);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("bp_release_vld", int'(out_valid[0]), 0);
        check("bp_release_rdy", int'(in_ready[0]), 1);
        run_req(0, 255, 1, "after_bp");

        // Reset in the middle of a search.
        @(negedge clk);
        in_valid[0] = 1'b1; y_in[0] = 8'd10; b_in[0] = 4'd3;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", int'(in_ready[0]), 1);
        check("midrst_out_valid", int'(out_valid[0]), 0);
        check("midrst_found", int'(found[0]), 0);
        check("midrst_a_out", int'(a_out[0]), 0);
        check("midrst_nmatch", int'(nmatch[0]), 0);
        run_req(0, 0, 0, "after_rst");
        check("after_rst_n1", int'(nmatch[0]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
